// File: rtl/buffer_8bit_to_10bit.sv
// Re-packs an LSB-first byte stream into 10-bit words (4 words per 5 bytes); optional comma alignment via BUFFER_8TO10_COMMA_ALIGN_EN.
// Latency: a word appears on data_out 1+PIPE_STAGES edges after the edge that samples its completing byte.
// Backpressure: none; in_valid=0 stalls the accumulator only, the output pipeline always shifts.
module buffer_8bit_to_10bit #(
    parameter int PIPE_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] data_in,
    input  logic       frame_start,
    output logic [9:0] data_out,
    output logic       valid_out,
    output logic       locked
);

    localparam int NS = PIPE_STAGES + 1;

    logic [15:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        locked_q, lock_d;
    logic        word_vld_q, wvld_d;
    logic [9:0]  word_dat_q, wdat_d;

    logic [23:0] app, app_al;
    logic [4:0]  sum, sum_al;

    logic [NS-1:0] pipe_vld_q;
    logic [9:0]    pipe_dat_q [NS];

`ifdef BUFFER_8TO10_COMMA_ALIGN_EN
    localparam logic [9:0] COMMA_N = 10'h17C;
    localparam logic [9:0] COMMA_P = 10'h283;
    logic       relock_q, relock_d;
    logic       hit;
    logic [2:0] hit_off;
`endif

    always_comb begin
        // New byte lands directly above the bits already held.
        app    = 24'(acc_q) | (24'(data_in) << cnt_q);
        sum    = cnt_q + 5'd8;
        app_al = app;
        sum_al = sum;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        lock_d = locked_q;
        wvld_d = 1'b0;
        wdat_d = word_dat_q;
`ifdef BUFFER_8TO10_COMMA_ALIGN_EN
        relock_d = 1'b0;
        hit      = 1'b0;
        hit_off  = 3'd0;
        if (relock_q) lock_d = 1'b1;
        for (int o = 0; o < 8; o++) begin
            if (!hit && (o + 10 <= int'(sum)) &&
                ((app[o +: 10] == COMMA_N) || (app[o +: 10] == COMMA_P))) begin
                hit     = 1'b1;
                hit_off = 3'(o);
            end
        end
        // Drop the bits ahead of the comma so it becomes the word emitted now.
        if (hit && (!locked_q || hit_off != 3'd0)) begin
            app_al = app >> hit_off;
            sum_al = sum - 5'(hit_off);
        end
`endif
        if (in_valid) begin
            if (frame_start) begin
                acc_d  = 16'(data_in);
                cnt_d  = 5'd8;
                lock_d = 1'b1;
            end else begin
`ifdef BUFFER_8TO10_COMMA_ALIGN_EN
                if (hit) begin
                    if (!locked_q) begin
                        lock_d = 1'b1;
                    end else if (hit_off != 3'd0) begin
                        lock_d   = 1'b0;
                        relock_d = 1'b1;
                    end
                end
`endif
                if (sum_al >= 5'd10) begin
                    wvld_d = 1'b1;
                    wdat_d = app_al[9:0];
                    acc_d  = 16'(app_al >> 10);
                    cnt_d  = sum_al - 5'd10;
                end else begin
                    acc_d  = app_al[15:0];
                    cnt_d  = sum_al;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            locked_q   <= 1'b0;
            word_vld_q <= 1'b0;
            word_dat_q <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < NS; i++) pipe_dat_q[i] <= '0;
`ifdef BUFFER_8TO10_COMMA_ALIGN_EN
            relock_q   <= 1'b0;
`endif
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            locked_q   <= lock_d;
            word_vld_q <= wvld_d;
            word_dat_q <= wdat_d;
            // Valid shifts every clock; data only moves with a valid so data_out holds between words.
            pipe_vld_q[0] <= word_vld_q;
            if (word_vld_q) pipe_dat_q[0] <= word_dat_q;
            for (int i = 1; i < NS; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                if (pipe_vld_q[i-1]) pipe_dat_q[i] <= pipe_dat_q[i-1];
            end
`ifdef BUFFER_8TO10_COMMA_ALIGN_EN
            relock_q   <= relock_d;
`endif
        end
    end

    assign data_out  = pipe_dat_q[NS-1];
    assign valid_out = pipe_vld_q[NS-1];
    assign locked    = locked_q;

endmodule

// File: tb/tb_buffer_8bit_to_10bit.sv
// Directed checks of byte-to-10-bit repacking, latency, stalls, resync and reset flush (default build, PIPE_STAGES=2).
module tb_buffer_8bit_to_10bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] data_in;
    logic       frame_start;
    logic [9:0] data_out;
    logic       valid_out;
    logic       locked;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [9:0] q_dat[$];
    int         q_cyc[$];

    buffer_8bit_to_10bit #(.PIPE_STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
        .frame_start(frame_start), .data_out(data_out), .valid_out(valid_out),
        .locked(locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            q_dat.push_back(data_out);
            q_cyc.push_back(cyc);
        end
    end

    task automatic put(input logic v, input logic f, input logic [7:0] b, output int e);
        in_valid = v; frame_start = f; data_in = b;
        @(posedge clk); #1;
        e = cyc;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; frame_start = 1'b0; data_in = 8'h00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0; data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q_dat.delete(); q_cyc.delete();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_out); end
        total++; if (data_out !== 10'h000) begin bad++; $display("FAIL reset_data got=%h want=000", data_out); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked); end
        idle(4);
        total++; if (q_dat.size() != 0) begin bad++; $display("FAIL reset_quiet got=%0d words want=0", q_dat.size()); end
    endtask

    task automatic test_unlocked();
        int e;
        do_reset();
        put(1'b1, 1'b0, 8'h03, e);
        put(1'b1, 1'b0, 8'h50, e);
        idle(5);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL unlocked_locked got=%b want=0", locked); end
        total++; if (q_dat.size() != 1) begin bad++; $display("FAIL unlocked_count got=%0d want=1", q_dat.size()); end
        else begin
            total++; if (q_dat[0] !== 10'h003) begin bad++; $display("FAIL unlocked_word got=%h want=003", q_dat[0]); end
        end
    endtask

    task automatic test_group();
        logic [7:0] b  [10] = '{8'hFF, 8'h03, 8'h50, 8'h95, 8'hAA, 8'hFF, 8'h03, 8'h50, 8'h95, 8'hAA};
        logic [9:0] ew [8]  = '{10'h3FF, 10'h000, 10'h155, 10'h2AA, 10'h3FF, 10'h000, 10'h155, 10'h2AA};
        int e [10];
        int idx;
        do_reset();
        for (int i = 0; i < 10; i++) put(1'b1, (i % 5) == 0, b[i], e[i]);
        idle(6);
        total++; if (q_dat.size() != 8) begin bad++; $display("FAIL group_count got=%0d want=8", q_dat.size()); end
        for (int j = 0; j < 8 && j < q_dat.size(); j++) begin
            idx = (j / 4) * 5 + (j % 4) + 1;
            total++; if (q_dat[j] !== ew[j]) begin bad++; $display("FAIL group_word%0d got=%h want=%h", j, q_dat[j], ew[j]); end
            total++; if (q_cyc[j] != e[idx] + 3) begin bad++; $display("FAIL group_lat%0d got=%0d want=%0d", j, q_cyc[j], e[idx] + 3); end
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL group_locked got=%b want=1", locked); end
        total++; if (data_out !== 10'h2AA) begin bad++; $display("FAIL group_hold got=%h want=2AA", data_out); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL group_idle_valid got=%b want=0", valid_out); end
    endtask

    task automatic test_stall();
        // Stall slots carry junk with frame_start set, which must be ignored.
        logic       v [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       f [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] b [7] = '{8'hFF, 8'h03, 8'hEE, 8'h50, 8'h95, 8'hEE, 8'hAA};
        logic [9:0] ew [4] = '{10'h3FF, 10'h000, 10'h155, 10'h2AA};
        int         ci [4] = '{1, 3, 4, 6};
        int e [7];
        do_reset();
        for (int i = 0; i < 7; i++) put(v[i], f[i], b[i], e[i]);
        idle(6);
        total++; if (q_dat.size() != 4) begin bad++; $display("FAIL stall_count got=%0d want=4", q_dat.size()); end
        for (int j = 0; j < 4 && j < q_dat.size(); j++) begin
            total++; if (q_dat[j] !== ew[j]) begin bad++; $display("FAIL stall_word%0d got=%h want=%h", j, q_dat[j], ew[j]); end
            total++; if (q_cyc[j] != e[ci[j]] + 3) begin bad++; $display("FAIL stall_lat%0d got=%0d want=%0d", j, q_cyc[j], e[ci[j]] + 3); end
        end
    endtask

    task automatic test_resync();
        logic [7:0] b [5] = '{8'hFF, 8'h03, 8'h50, 8'h12, 8'h34};
        logic       f [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [9:0] ew [3] = '{10'h3FF, 10'h000, 10'h012};
        int e [5];
        do_reset();
        for (int i = 0; i < 5; i++) put(1'b1, f[i], b[i], e[i]);
        idle(6);
        total++; if (q_dat.size() != 3) begin bad++; $display("FAIL resync_count got=%0d want=3", q_dat.size()); end
        for (int j = 0; j < 3 && j < q_dat.size(); j++) begin
            total++; if (q_dat[j] !== ew[j]) begin bad++; $display("FAIL resync_word%0d got=%h want=%h", j, q_dat[j], ew[j]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b [5] = '{8'hFF, 8'h03, 8'h50, 8'h95, 8'hAA};
        logic [9:0] ew [4] = '{10'h3FF, 10'h000, 10'h155, 10'h2AA};
        int e;
        do_reset();
        put(1'b1, 1'b1, 8'hFF, e);
        put(1'b1, 1'b0, 8'h03, e);
        put(1'b1, 1'b0, 8'h50, e);
        rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", valid_out); end
        total++; if (data_out !== 10'h000) begin bad++; $display("FAIL rstmid_data got=%h want=000", data_out); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rstmid_locked got=%b want=0", locked); end
        idle(6);
        total++; if (q_dat.size() != 0) begin bad++; $display("FAIL rstmid_stale got=%0d words want=0", q_dat.size()); end
        for (int i = 0; i < 5; i++) put(1'b1, i == 0, b[i], e);
        idle(6);
        total++; if (q_dat.size() != 4) begin bad++; $display("FAIL rstmid_count got=%0d want=4", q_dat.size()); end
        for (int j = 0; j < 4 && j < q_dat.size(); j++) begin
            total++; if (q_dat[j] !== ew[j]) begin bad++; $display("FAIL rstmid_word%0d got=%h want=%h", j, q_dat[j], ew[j]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] ew[$];
        logic [39:0] s;
        logic [9:0] w [4];
        int e, first, hits;
        do_reset();
        for (int g = 0; g < 16; g++) begin
            for (int k = 0; k < 4; k++) begin
                w[k] = 10'($urandom_range(0, 1023));
                ew.push_back(w[k]);
            end
            s = {w[3], w[2], w[1], w[0]};
            for (int k = 0; k < 5; k++) put(1'b1, (g == 0) && (k == 0), s[8*k +: 8], e);
        end
        idle(6);
        total++; if (q_dat.size() != 64) begin bad++; $display("FAIL b2b_count got=%0d want=64", q_dat.size()); end
        for (int j = 0; j < 64 && j < q_dat.size(); j++) begin
            total++; if (q_dat[j] !== ew[j]) begin bad++; $display("FAIL b2b_word%0d got=%h want=%h", j, q_dat[j], ew[j]); end
        end
        if (q_cyc.size() > 20) begin
            first = q_cyc[20];
            hits = 0;
            foreach (q_cyc[j]) if (q_cyc[j] >= first && q_cyc[j] < first + 10) hits++;
            total++; if (hits != 8) begin bad++; $display("FAIL b2b_density got=%0d want=8", hits); end
        end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL b2b_locked got=%b want=1", locked); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0; data_in = 8'h00;
        test_reset();
        test_unlocked();
        test_group();
        test_stall();
        test_resync();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
